// File: rtl/sb_stream_pkg.sv
// Shared constants and lane-operation helper for the stream transform block.
package sb_stream_pkg;

    localparam int unsigned LANE_W = 64;

    typedef enum logic [1:0] {
        ADD = 2'd0,
        SUB = 2'd1,
        XOR = 2'd2
    } mode_e;

    // Arithmetic wraps at the lane width, so no carry or borrow ever leaves a lane.
    function automatic logic [LANE_W-1:0] lane_op(input mode_e m,
                                                  input logic [LANE_W-1:0] a,
                                                  input logic [LANE_W-1:0] b);
        case (m)
            ADD:     return a + b;
            SUB:     return a - b;
            XOR:     return a ^ b;
            default: return a;
        endcase
    endfunction

endpackage

// File: rtl/sb_stream_fifo.sv
// Synchronous FIFO with registered occupancy; accepts nothing until one edge after reset release.
module sb_stream_fifo
    import sb_stream_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned AW   = $clog2(DEPTH),
    localparam int unsigned LW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             nreset,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             wr_valid,
    output logic             wr_ready,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [LW-1:0]    level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LW-1:0]    count;
    logic             live;
    logic             push;
    logic             pop;

    // Full check ignores a same-cycle pop so wr_ready never depends on rd_ready.
    assign wr_ready = live && (count != LW'(DEPTH));
    assign rd_valid = (count != '0);
    assign push     = wr_valid && wr_ready;
    assign pop      = rd_valid && rd_ready;
    assign rd_data  = mem[rd_ptr];
    assign level    = count;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            live   <= 1'b0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            live <= 1'b1;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/sb_stream_xform.sv
// Stream stage: transforms low-order 64-bit lanes at write time, buffers words, tracks packets and terminator.
module sb_stream_xform
    import sb_stream_pkg::*;
#(
    parameter int unsigned DW    = 256,
    parameter int unsigned LANES = 1,
    parameter logic [63:0] INC   = 64'd42,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned MODE  = 0
) (
    input  logic                       clk,
    input  logic                       nreset,
    input  logic                       en,
    input  logic [DW-1:0]              rx_data,
    input  logic [31:0]                rx_dest,
    input  logic                       rx_last,
    input  logic                       rx_valid,
    output logic                       rx_ready,
    output logic [DW-1:0]              tx_data,
    output logic [31:0]                tx_dest,
    output logic                       tx_last,
    output logic                       tx_valid,
    input  logic                       tx_ready,
    output logic                       done,
    output logic [31:0]                pkt_count,
    output logic [$clog2(DEPTH+1)-1:0] level
);

    localparam mode_e OP = mode_e'(MODE[1:0]);
    localparam int unsigned FW = DW + 33;

    logic [DW-1:0] xf_data;
    logic          is_term;
    logic          accept;
    logic [FW-1:0] fifo_rd;

    assign is_term = &rx_data;
    assign accept  = rx_valid && rx_ready;

    always_comb begin
        xf_data = rx_data;
        if (en && !is_term) begin
            for (int unsigned k = 0; k < LANES; k++) begin
                xf_data[k*LANE_W +: LANE_W] = lane_op(OP, rx_data[k*LANE_W +: LANE_W], INC);
            end
        end
    end

    sb_stream_fifo #(
        .WIDTH (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .nreset   (nreset),
        .wr_data  ({rx_last, rx_dest, xf_data}),
        .wr_valid (rx_valid),
        .wr_ready (rx_ready),
        .rd_data  (fifo_rd),
        .rd_valid (tx_valid),
        .rd_ready (tx_ready),
        .level    (level)
    );

    assign {tx_last, tx_dest, tx_data} = fifo_rd;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            done      <= 1'b0;
            pkt_count <= '0;
        end else begin
            if (accept && is_term) done <= 1'b1;
            if (accept && rx_last && (pkt_count != '1)) pkt_count <= pkt_count + 32'd1;
        end
    end

endmodule

// File: doc/sb_stream_xform.md
SB_STREAM_XFORM -- requirements
Module: sb_stream_xform

Interface
REQ-001 Parameter DW, default 256: data width of the RX and TX streams, a multiple of 64, minimum 64.
REQ-002 Parameter LANES, default 1: number of low-order 64-bit lanes transformed, 1..DW/64.
REQ-003 Parameter INC, default 64'd42: 64-bit operand applied to each transformed lane.
REQ-004 Parameter DEPTH, default 4: buffer depth in words, a power of two, minimum 2.
REQ-005 Parameter MODE, default 0: 0 = add INC, 1 = subtract INC, 2 = XOR INC.
REQ-006 clk  input  1  the single clock; all state changes on its rising edge.
REQ-007 nreset  input  1  asynchronous, active-low reset.
REQ-008 en  input  1  1 = transform lanes; 0 = pass data through unmodified; sampled per accepted word.
REQ-009 rx_data  input  DW  inbound word.
REQ-010 rx_dest  input  32  inbound destination.
REQ-011 rx_last  input  1  inbound end-of-packet flag.
REQ-012 rx_valid  input  1  inbound word valid.
REQ-013 rx_ready  output  1  block can accept a word.
REQ-014 tx_data  output  DW  outbound word.
REQ-015 tx_dest  output  32  outbound destination.
REQ-016 tx_last  output  1  outbound end-of-packet flag.
REQ-017 tx_valid  output  1  outbound word valid.
REQ-018 tx_ready  input  1  downstream can accept a word.
REQ-019 done  output  1  sticky flag: terminator word has been accepted.
REQ-020 pkt_count  output  32  saturating count of accepted words with rx_last=1.
REQ-021 level  output  $clog2(DEPTH+1)  current buffer occupancy.

Function
REQ-022 RX transfer occurs when rx_valid && rx_ready; TX transfer occurs when tx_valid && tx_ready.
REQ-023 rx_ready shall equal (level != DEPTH); a full buffer does not accept a word, even when a TX pop happens in the same cycle.
REQ-024 tx_valid shall equal (level != 0); a word accepted into an empty buffer at edge N is presented from edge N onward, so first output valid is 1 cycle after acceptance, with no combinational rx-to-tx path.
REQ-025 Words leave in acceptance order; dest and last travel unchanged with their data.
REQ-026 Lane k (bits 64k+63:64k, k<LANES) of a stored word = f(rx lane k, INC) modulo 2^64 per MODE; a carry never crosses a lane boundary; lanes k>=LANES are copied unmodified.
REQ-027 The transform is applied at write time using en sampled in the same cycle.
REQ-028 A terminator is an accepted word with all DW data bits set; it is stored unmodified regardless of en.
REQ-029 done rises on the edge after a terminator is accepted and stays 1 until reset.
REQ-030 Words offered after done are still accepted and forwarded.
REQ-031 pkt_count increments by 1 per accepted rx_last=1 word and holds at 32'hFFFFFFFF.
REQ-032 On simultaneous push and pop, level is unchanged; read and write pointers wrap modulo DEPTH.
REQ-033 tx_data, tx_dest and tx_last shall stay stable while tx_valid && !tx_ready.

Reset
REQ-034 While nreset=0, the following shall hold: level=0, tx_valid=0, rx_ready=0, done=0, pkt_count=0, pointers=0.
REQ-035 rx_ready rises on the first clk edge after nreset deasserts.
REQ-036 Reset asserted mid-transfer discards all buffered words; no partial packet is emitted after release.

Structure
REQ-037 Package sb_stream_pkg holds the LANE_W=64 constant and the mode enumeration (ADD, SUB, XOR).
REQ-038 Buffering is a single sub-module, sb_stream_fifo, parametrised by width (DW+33) and DEPTH; transform, done and counter logic sit in sb_stream_xform.

Verification
REQ-039 Default parameters, en=1, send lane0=5 and lane1=7 -> tx lane0=47, lane1=7, output 1 cycle after accept.
REQ-040 Lane0=64'hFFFFFFFFFFFFFFF0, LANES=2, lane1=0 -> tx lane0=64'h1A, lane1=42, no carry into lane1.
REQ-041 tx_ready=0 while 6 words are sent with DEPTH=4 -> rx_ready drops after 4th, level=4, words 1-4 then 5-6 emerge in order once tx_ready=1.
REQ-042 Send 3 packets (last on words 2, 4, 5), then an all-ones word -> pkt_count=3, done=1 next cycle, all-ones word forwarded unchanged.
REQ-043 MODE=2, en toggled 1,0,1 across lane0=1 words -> tx lane0 = 43, 1, 43.
REQ-044 Assert nreset with 3 words buffered -> tx_valid=0, level=0, done=0 immediately; rx_ready=1 one edge after release.
